// File: rtl/strobe_rx_sync_ff.sv
// Multi-stage single-bit synchronizer for toggle crossings; DELAY clk edges of latency.
// No backpressure: it samples every edge, and all stages reset to 0.
module sync_ff #(
  parameter int DELAY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DELAY-1:0] sync_q;
  logic [DELAY-1:0] sync_d;

  // Pure shift chain: nothing may sit between stages, or metastability filtering is lost.
  always_comb begin
    sync_d = {sync_q[DELAY-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DELAY-1];

endmodule

// File: rtl/strobe_rx.sv
// Toggle-handshake receiver: word visible and ack flipped DELAY+1 edges after req flips.
// A full 2-entry buffer withholds the ack, which stalls the remote sender.
module strobe_rx #(
  parameter int WIDTH = 8,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_toggle_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_toggle_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [1:0]       count
);

  logic             req_s;
  logic             pending;
  logic             pop;
  logic             push;

  logic             ack_q,   ack_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q,  ent0_d;
  logic [WIDTH-1:0] ent1_q,  ent1_d;

  sync_ff #(.DELAY(DELAY)) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (req_toggle_in),
    .q       (req_s)
  );

  assign valid_out = (count_q != 2'd0);
  assign pending   = req_s ^ ack_q;
  assign pop       = valid_out & ready_in;
  assign push      = pending & ((count_q < 2'd2) | pop);

  always_comb begin
    ack_d   = ack_q;
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;

    if (pop && (count_q == 2'd2)) begin
      ent0_d = ent1_q;
    end

    // The tail slot depends on occupancy and on whether the head leaves this edge.
    if (push) begin
      ack_d = ~ack_q;
      unique case (count_q)
        2'd0: ent0_d = data_in;
        2'd1: begin
          if (pop) begin
            ent0_d = data_in;
          end else begin
            ent1_d = data_in;
          end
        end
        default: ent1_d = data_in;
      endcase
    end

    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      ack_q   <= ack_d;
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign ack_toggle_out = ack_q;
  assign data_out       = ent0_q;
  assign count          = count_q;

endmodule

// File: tb/tb_strobe_rx.sv
// Bench for strobe_rx: a toggle-protocol sender, a ready driver and a scoreboard of
// expected words, checked whenever a word leaves the DUT.
module tb_strobe_rx;

  localparam int WIDTH = 8;
  localparam int DELAY = 2;

  logic             clk;
  logic             reset_n;
  logic             req_toggle_in;
  logic [WIDTH-1:0] data_in;
  logic             ack_toggle_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic [1:0]       count;

  int n_checks;
  int n_fail;
  logic [WIDTH-1:0] exp_q[$];

  strobe_rx #(.WIDTH(WIDTH), .DELAY(DELAY)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_toggle_in  (req_toggle_in),
    .data_in        (data_in),
    .ack_toggle_out (ack_toggle_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a word leaves on the next posedge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (reset_n && valid_out && ready_in) begin
      logic [WIDTH-1:0] exp;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: data_out=%h with no word outstanding", data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp) begin
          n_fail++;
          $display("FAIL out_order: data_out=%h required %h", data_out, exp);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n       = 1'b0;
    req_toggle_in = 1'b0;
    data_in       = '0;
    ready_in      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    @(posedge clk);
    #1;
    data_in       = w;
    req_toggle_in = ~req_toggle_in;
    exp_q.push_back(w);
  endtask

  task automatic wait_ack();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ack_toggle_out === req_toggle_in) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_timeout: ack=%b required %b", ack_toggle_out, req_toggle_in);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && count === 2'd0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, count=%0d required 0", exp_q.size(), count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks += 4;
    if (ack_toggle_out !== 1'b0) begin n_fail++; $display("FAIL reset_ack: %b required 0", ack_toggle_out); end
    if (count !== 2'd0)          begin n_fail++; $display("FAIL reset_count: %0d required 0", count); end
    if (valid_out !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: %b required 0", valid_out); end
    if (data_out !== '0)         begin n_fail++; $display("FAIL reset_data: %h required 00", data_out); end
  endtask

  task automatic test_single();
    do_reset();
    ready_in = 1'b1;
    send(8'hA5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 2;
    if (valid_out !== 1'b0)      begin n_fail++; $display("FAIL single_early_valid: %b required 0", valid_out); end
    if (ack_toggle_out !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: %b required 0", ack_toggle_out); end
    @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (ack_toggle_out !== 1'b1) begin n_fail++; $display("FAIL single_ack: %b required 1", ack_toggle_out); end
    if (valid_out !== 1'b1)      begin n_fail++; $display("FAIL single_valid: %b required 1", valid_out); end
    if (data_out !== 8'hA5)      begin n_fail++; $display("FAIL single_data: %h required a5", data_out); end
    @(negedge clk);
    n_checks += 2;
    if (valid_out !== 1'b0)      begin n_fail++; $display("FAIL single_valid_after: %b required 0", valid_out); end
    if (count !== 2'd0)          begin n_fail++; $display("FAIL single_count_after: %0d required 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    do_reset();
    ready_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      w = WIDTH'(i);
      send(w);
      wait_ack();
    end
    wait_drain();
    n_checks++;
    if (ack_toggle_out !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_parity: %b required 0", ack_toggle_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    send(8'h11); wait_ack();
    send(8'h22); wait_ack();
    send(8'h33);
    repeat (8) @(negedge clk);
    n_checks += 4;
    if (count !== 2'd2)          begin n_fail++; $display("FAIL bp_count_full: %0d required 2", count); end
    if (data_out !== 8'h11)      begin n_fail++; $display("FAIL bp_head: %h required 11", data_out); end
    if (ack_toggle_out !== 1'b0) begin n_fail++; $display("FAIL bp_ack_held: %b required 0", ack_toggle_out); end
    if (valid_out !== 1'b1)      begin n_fail++; $display("FAIL bp_valid_held: %b required 1", valid_out); end
    @(posedge clk);
    #1 ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (ack_toggle_out !== 1'b1) begin n_fail++; $display("FAIL bp_ack_release: %b required 1", ack_toggle_out); end
    if (count !== 2'd2)          begin n_fail++; $display("FAIL bp_count_pushpop: %0d required 2", count); end
    if (data_out !== 8'h22)      begin n_fail++; $display("FAIL bp_head_shift: %h required 22", data_out); end
    wait_drain();
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    send(8'h5A); wait_ack();
    send(8'hC3);
    @(posedge clk);
    @(posedge clk);
    #1 ready_in = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (count !== 2'd1)     begin n_fail++; $display("FAIL pp_count_before: %0d required 1", count); end
    if (data_out !== 8'h5A) begin n_fail++; $display("FAIL pp_head_before: %h required 5a", data_out); end
    @(negedge clk);
    n_checks += 3;
    if (count !== 2'd1)          begin n_fail++; $display("FAIL pp_count_after: %0d required 1", count); end
    if (data_out !== 8'hC3)      begin n_fail++; $display("FAIL pp_head_after: %h required c3", data_out); end
    if (ack_toggle_out !== 1'b0) begin n_fail++; $display("FAIL pp_ack: %b required 0", ack_toggle_out); end
    wait_drain();
  endtask

  task automatic test_data_instability();
    logic [WIDTH-1:0] words [3];
    words[0] = 8'h3C; words[1] = 8'h96; words[2] = 8'hF0;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        #1 data_in = WIDTH'($urandom);
      end
      send(words[i]);
      wait_ack();
      @(posedge clk);
      #1 data_in = ~words[i];
    end
    wait_drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    send(8'h11); wait_ack();
    send(8'h22); wait_ack();
    send(8'h33);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_checks += 4;
    if (count !== 2'd0)          begin n_fail++; $display("FAIL ar_count: %0d required 0", count); end
    if (valid_out !== 1'b0)      begin n_fail++; $display("FAIL ar_valid: %b required 0", valid_out); end
    if (ack_toggle_out !== 1'b0) begin n_fail++; $display("FAIL ar_ack: %b required 0", ack_toggle_out); end
    if (data_out !== '0)         begin n_fail++; $display("FAIL ar_data: %h required 00", data_out); end
    req_toggle_in = 1'b0;
    exp_q.delete();
    #1 reset_n = 1'b1;
    ready_in = 1'b1;
    send(8'h7E);
    wait_ack();
    n_checks++;
    if (ack_toggle_out !== 1'b1) begin n_fail++; $display("FAIL ar_fresh_ack: %b required 1", ack_toggle_out); end
    wait_drain();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_data_instability();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_rx.md
Name: strobe_rx

Overview:
- Receiving end of a two-phase (toggle) request/acknowledge crossing, clocked entirely in the destination domain.
- The remote sender sets data_in, flips req_toggle_in, and holds data_in until it sees ack_toggle_out match.
- This block synchronizes the request and captures the word into a 2-entry buffer. It returns the ack toggle only once the word is stored, so a full buffer back-pressures the remote sender.
- Data is presented downstream on a valid/ready interface. Sits at the destination side of a domain crossing.

Parameters:
WIDTH, 8, bits per transferred word
DELAY, 2, synchronizer stages on req_toggle_in (legal range 2..4)

Ports:
clk  input  1  destination-domain clock
reset_n  input  1  asynchronous active-low reset
req_toggle_in  input  1  request toggle from remote domain; asynchronous to clk
data_in  input  WIDTH  remote data word; guaranteed stable from req flip until matching ack is seen remotely
ack_toggle_out  output  1  acknowledge toggle returned to the remote domain; registered
data_out  output  WIDTH  head-of-buffer word
valid_out  output  1  data_out holds a valid word
ready_in  input  1  downstream accepts data_out this cycle
count  output  2  buffer occupancy, 0..2

Behaviour:
- Reset (reset_n low, asynchronous):
  - sync chain = 0, ack_toggle_out = 0, count = 0, valid_out = 0, data_out = 0, buffer entries = 0.
  - Both ends of the link are reset together; toggle parity starts equal (0/0).
- Synchronizer: req_toggle_in shifts through DELAY flops; req_s = last stage. No logic between stages.
- pending = req_s XOR ack_toggle_out (combinational).
- pop = valid_out AND ready_in.
- push = pending AND (count < 2 OR pop).
- On a clk edge with push:
  - Write data_in into the tail entry.
  - Flip ack_toggle_out in the same edge, so pending deasserts the following cycle.
  - Only one push can occur per remote request.
- Buffer: 2-entry FIFO. Entry 0 is the head and drives data_out directly from a register.
  - pop with count = 2: entry 1 shifts into entry 0.
  - push with count = 0: data goes to entry 0.
  - push with count = 1 and no pop: data goes to entry 1.
  - push and pop with count = 1: data goes to entry 0.
  - push and pop with count = 2: entry 1 moves to entry 0 and new data goes to entry 1; count stays 2.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. valid_out = (count != 0), registered-equivalent.
- Latency:
  - req_toggle_in edge to valid_out high is DELAY+1 clk edges when the buffer is empty.
  - req_toggle_in edge to ack_toggle_out flip is the same DELAY+1 edges.
- Full: count = 2, pending = 1, no pop → no capture and ack held. The remote sender stalls.
  - When ready_in rises, push and pop occur in the same cycle; ack flips that edge.
- data_out is stable and valid_out stays high while ready_in = 0; no word is ever dropped or duplicated.
- ready_in while count = 0 has no effect.
- data_in is sampled only on push edges; its value at other times is ignored. DELAY ≥ 2 guarantees data_in settled before the sample.
- Reset mid-transfer discards buffered words and returns ack parity to 0.

Decomposition:
- No shared package needed; WIDTH and DELAY are local parameters.
- One sub-module: sync_ff (DELAY-stage single-bit synchronizer with clk/reset_n, reset value 0), reusable for other toggle crossings.
- Buffer, pointer/count logic and ack register stay in strobe_rx.

Test Plan:
- Single transfer: reset, data_in = 8'hA5, flip req to 1, ready_in = 1 → ack_toggle_out = 1 and valid_out = 1 with data_out = A5 after exactly 3 edges (DELAY = 2); valid_out low next cycle; count returns to 0.
- Back-to-back (bench sender reacts to ack): words 01, 02, 03, 04 with ready_in = 1 → data_out yields 01, 02, 03, 04 in order; ack toggles 4 times ending at 0; no duplicates.
- Backpressure: ready_in = 0, send 11, 22, 33 → count = 2 holding 11, 22; ack parity reflects 2 flips only; third request pending. Raise ready_in → 11 popped, 33 captured same cycle, ack flips, output order 11, 22, 33.
- Simultaneous push/pop at count = 1: head = 5A, ready_in = 1 on the edge a new word C3 is captured → count stays 1, data_out = C3 next cycle.
- data_in instability: data_in changes every cycle except during the request window → captured word equals the value held at the req flip.
- Async reset mid-operation: count = 2, pending request, pulse reset_n low between clock edges → outputs go to reset values immediately; after release a fresh transfer of 7E completes with ack = 1.
